aes256_decrypt_core: RTL and testbench



---
 rtl/aes_pkg.sv | 138 +++++++++++++
 rtl/aes256_decrypt_core_if.sv | 26 ++
 rtl/aes256_key_schedule.sv | 67 ++++++
 rtl/aes256_decrypt_core.sv | 124 ++++++++++++
 tb/tb_aes256_decrypt_core.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, types and byte-level helpers
// for the AES-256 encrypt and decrypt datapaths.
package aes_pkg;

   localparam int NR = 14;
   localparam int NK = 8;
   localparam int NW = 60;

   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   typedef enum logic [2:0] {
      S_NOKEY,
      S_EXPAND,
      S_IDLE,
      S_ROUND,
      S_OUT
   } fsm_e;

   function automatic byte_t sbox(input byte_t b);
      byte_t r;
      r = 8'h00;
      case (b)
         8'h00:r=8'h63; 8'h01:r=8'h7c; 8'h02:r=8'h77; 8'h03:r=8'h7b; 8'h04:r=8'hf2; 8'h05:r=8'h6b; 8'h06:r=8'h6f; 8'h07:r=8'hc5;
         8'h08:r=8'h30; 8'h09:r=8'h01; 8'h0a:r=8'h67; 8'h0b:r=8'h2b; 8'h0c:r=8'hfe; 8'h0d:r=8'hd7; 8'h0e:r=8'hab; 8'h0f:r=8'h76;
         8'h10:r=8'hca; 8'h11:r=8'h82; 8'h12:r=8'hc9; 8'h13:r=8'h7d; 8'h14:r=8'hfa; 8'h15:r=8'h59; 8'h16:r=8'h47; 8'h17:r=8'hf0;
         8'h18:r=8'had; 8'h19:r=8'hd4; 8'h1a:r=8'ha2; 8'h1b:r=8'haf; 8'h1c:r=8'h9c; 8'h1d:r=8'ha4; 8'h1e:r=8'h72; 8'h1f:r=8'hc0;
         8'h20:r=8'hb7; 8'h21:r=8'hfd; 8'h22:r=8'h93; 8'h23:r=8'h26; 8'h24:r=8'h36; 8'h25:r=8'h3f; 8'h26:r=8'hf7; 8'h27:r=8'hcc;
         8'h28:r=8'h34; 8'h29:r=8'ha5; 8'h2a:r=8'he5; 8'h2b:r=8'hf1; 8'h2c:r=8'h71; 8'h2d:r=8'hd8; 8'h2e:r=8'h31; 8'h2f:r=8'h15;
         8'h30:r=8'h04; 8'h31:r=8'hc7; 8'h32:r=8'h23; 8'h33:r=8'hc3; 8'h34:r=8'h18; 8'h35:r=8'h96; 8'h36:r=8'h05; 8'h37:r=8'h9a;
         8'h38:r=8'h07; 8'h39:r=8'h12; 8'h3a:r=8'h80; 8'h3b:r=8'he2; 8'h3c:r=8'heb; 8'h3d:r=8'h27; 8'h3e:r=8'hb2; 8'h3f:r=8'h75;
         8'h40:r=8'h09; 8'h41:r=8'h83; 8'h42:r=8'h2c; 8'h43:r=8'h1a; 8'h44:r=8'h1b; 8'h45:r=8'h6e; 8'h46:r=8'h5a; 8'h47:r=8'ha0;
         8'h48:r=8'h52; 8'h49:r=8'h3b; 8'h4a:r=8'hd6; 8'h4b:r=8'hb3; 8'h4c:r=8'h29; 8'h4d:r=8'he3; 8'h4e:r=8'h2f; 8'h4f:r=8'h84;
         8'h50:r=8'h53; 8'h51:r=8'hd1; 8'h52:r=8'h00; 8'h53:r=8'hed; 8'h54:r=8'h20; 8'h55:r=8'hfc; 8'h56:r=8'hb1; 8'h57:r=8'h5b;
         8'h58:r=8'h6a; 8'h59:r=8'hcb; 8'h5a:r=8'hbe; 8'h5b:r=8'h39; 8'h5c:r=8'h4a; 8'h5d:r=8'h4c; 8'h5e:r=8'h58; 8'h5f:r=8'hcf;
         8'h60:r=8'hd0; 8'h61:r=8'hef; 8'h62:r=8'haa; 8'h63:r=8'hfb; 8'h64:r=8'h43; 8'h65:r=8'h4d; 8'h66:r=8'h33; 8'h67:r=8'h85;
         8'h68:r=8'h45; 8'h69:r=8'hf9; 8'h6a:r=8'h02; 8'h6b:r=8'h7f; 8'h6c:r=8'h50; 8'h6d:r=8'h3c; 8'h6e:r=8'h9f; 8'h6f:r=8'ha8;
         8'h70:r=8'h51; 8'h71:r=8'ha3; 8'h72:r=8'h40; 8'h73:r=8'h8f; 8'h74:r=8'h92; 8'h75:r=8'h9d; 8'h76:r=8'h38; 8'h77:r=8'hf5;
         8'h78:r=8'hbc; 8'h79:r=8'hb6; 8'h7a:r=8'hda; 8'h7b:r=8'h21; 8'h7c:r=8'h10; 8'h7d:r=8'hff; 8'h7e:r=8'hf3; 8'h7f:r=8'hd2;
         8'h80:r=8'hcd; 8'h81:r=8'h0c; 8'h82:r=8'h13; 8'h83:r=8'hec; 8'h84:r=8'h5f; 8'h85:r=8'h97; 8'h86:r=8'h44; 8'h87:r=8'h17;
         8'h88:r=8'hc4; 8'h89:r=8'ha7; 8'h8a:r=8'h7e; 8'h8b:r=8'h3d; 8'h8c:r=8'h64; 8'h8d:r=8'h5d; 8'h8e:r=8'h19; 8'h8f:r=8'h73;
         8'h90:r=8'h60; 8'h91:r=8'h81; 8'h92:r=8'h4f; 8'h93:r=8'hdc; 8'h94:r=8'h22; 8'h95:r=8'h2a; 8'h96:r=8'h90; 8'h97:r=8'h88;
         8'h98:r=8'h46; 8'h99:r=8'hee; 8'h9a:r=8'hb8; 8'h9b:r=8'h14; 8'h9c:r=8'hde; 8'h9d:r=8'h5e; 8'h9e:r=8'h0b; 8'h9f:r=8'hdb;
         8'ha0:r=8'he0; 8'ha1:r=8'h32; 8'ha2:r=8'h3a; 8'ha3:r=8'h0a; 8'ha4:r=8'h49; 8'ha5:r=8'h06; 8'ha6:r=8'h24; 8'ha7:r=8'h5c;
         8'ha8:r=8'hc2; 8'ha9:r=8'hd3; 8'haa:r=8'hac; 8'hab:r=8'h62; 8'hac:r=8'h91; 8'had:r=8'h95; 8'hae:r=8'he4; 8'haf:r=8'h79;
         8'hb0:r=8'he7; 8'hb1:r=8'hc8; 8'hb2:r=8'h37; 8'hb3:r=8'h6d; 8'hb4:r=8'h8d; 8'hb5:r=8'hd5; 8'hb6:r=8'h4e; 8'hb7:r=8'ha9;
         8'hb8:r=8'h6c; 8'hb9:r=8'h56; 8'hba:r=8'hf4; 8'hbb:r=8'hea; 8'hbc:r=8'h65; 8'hbd:r=8'h7a; 8'hbe:r=8'hae; 8'hbf:r=8'h08;
         8'hc0:r=8'hba; 8'hc1:r=8'h78; 8'hc2:r=8'h25; 8'hc3:r=8'h2e; 8'hc4:r=8'h1c; 8'hc5:r=8'ha6; 8'hc6:r=8'hb4; 8'hc7:r=8'hc6;
         8'hc8:r=8'he8; 8'hc9:r=8'hdd; 8'hca:r=8'h74; 8'hcb:r=8'h1f; 8'hcc:r=8'h4b; 8'hcd:r=8'hbd; 8'hce:r=8'h8b; 8'hcf:r=8'h8a;
         8'hd0:r=8'h70; 8'hd1:r=8'h3e; 8'hd2:r=8'hb5; 8'hd3:r=8'h66; 8'hd4:r=8'h48; 8'hd5:r=8'h03; 8'hd6:r=8'hf6; 8'hd7:r=8'h0e;
         8'hd8:r=8'h61; 8'hd9:r=8'h35; 8'hda:r=8'h57; 8'hdb:r=8'hb9; 8'hdc:r=8'h86; 8'hdd:r=8'hc1; 8'hde:r=8'h1d; 8'hdf:r=8'h9e;
         8'he0:r=8'he1; 8'he1:r=8'hf8; 8'he2:r=8'h98; 8'he3:r=8'h11; 8'he4:r=8'h69; 8'he5:r=8'hd9; 8'he6:r=8'h8e; 8'he7:r=8'h94;
         8'he8:r=8'h9b; 8'he9:r=8'h1e; 8'hea:r=8'h87; 8'heb:r=8'he9; 8'hec:r=8'hce; 8'hed:r=8'h55; 8'hee:r=8'h28; 8'hef:r=8'hdf;
         8'hf0:r=8'h8c; 8'hf1:r=8'ha1; 8'hf2:r=8'h89; 8'hf3:r=8'h0d; 8'hf4:r=8'hbf; 8'hf5:r=8'he6; 8'hf6:r=8'h42; 8'hf7:r=8'h68;
         8'hf8:r=8'h41; 8'hf9:r=8'h99; 8'hfa:r=8'h2d; 8'hfb:r=8'h0f; 8'hfc:r=8'hb0; 8'hfd:r=8'h54; 8'hfe:r=8'hbb; 8'hff:r=8'h16;
      endcase
      return r;
   endfunction

   function automatic byte_t inv_sbox(input byte_t b);
      byte_t r;
      r = 8'h00;
      case (b)
         8'h00:r=8'h52; 8'h01:r=8'h09; 8'h02:r=8'h6a; 8'h03:r=8'hd5; 8'h04:r=8'h30; 8'h05:r=8'h36; 8'h06:r=8'ha5; 8'h07:r=8'h38;
         8'h08:r=8'hbf; 8'h09:r=8'h40; 8'h0a:r=8'ha3; 8'h0b:r=8'h9e; 8'h0c:r=8'h81; 8'h0d:r=8'hf3; 8'h0e:r=8'hd7; 8'h0f:r=8'hfb;
         8'h10:r=8'h7c; 8'h11:r=8'he3; 8'h12:r=8'h39; 8'h13:r=8'h82; 8'h14:r=8'h9b; 8'h15:r=8'h2f; 8'h16:r=8'hff; 8'h17:r=8'h87;
         8'h18:r=8'h34; 8'h19:r=8'h8e; 8'h1a:r=8'h43; 8'h1b:r=8'h44; 8'h1c:r=8'hc4; 8'h1d:r=8'hde; 8'h1e:r=8'he9; 8'h1f:r=8'hcb;
         8'h20:r=8'h54; 8'h21:r=8'h7b; 8'h22:r=8'h94; 8'h23:r=8'h32; 8'h24:r=8'ha6; 8'h25:r=8'hc2; 8'h26:r=8'h23; 8'h27:r=8'h3d;
         8'h28:r=8'hee; 8'h29:r=8'h4c; 8'h2a:r=8'h95; 8'h2b:r=8'h0b; 8'h2c:r=8'h42; 8'h2d:r=8'hfa; 8'h2e:r=8'hc3; 8'h2f:r=8'h4e;
         8'h30:r=8'h08; 8'h31:r=8'h2e; 8'h32:r=8'ha1; 8'h33:r=8'h66; 8'h34:r=8'h28; 8'h35:r=8'hd9; 8'h36:r=8'h24; 8'h37:r=8'hb2;
         8'h38:r=8'h76; 8'h39:r=8'h5b; 8'h3a:r=8'ha2; 8'h3b:r=8'h49; 8'h3c:r=8'h6d; 8'h3d:r=8'h8b; 8'h3e:r=8'hd1; 8'h3f:r=8'h25;
         8'h40:r=8'h72; 8'h41:r=8'hf8; 8'h42:r=8'hf6; 8'h43:r=8'h64; 8'h44:r=8'h86; 8'h45:r=8'h68; 8'h46:r=8'h98; 8'h47:r=8'h16;
         8'h48:r=8'hd4; 8'h49:r=8'ha4; 8'h4a:r=8'h5c; 8'h4b:r=8'hcc; 8'h4c:r=8'h5d; 8'h4d:r=8'h65; 8'h4e:r=8'hb6; 8'h4f:r=8'h92;
         8'h50:r=8'h6c; 8'h51:r=8'h70; 8'h52:r=8'h48; 8'h53:r=8'h50; 8'h54:r=8'hfd; 8'h55:r=8'hed; 8'h56:r=8'hb9; 8'h57:r=8'hda;
         8'h58:r=8'h5e; 8'h59:r=8'h15; 8'h5a:r=8'h46; 8'h5b:r=8'h57; 8'h5c:r=8'ha7; 8'h5d:r=8'h8d; 8'h5e:r=8'h9d; 8'h5f:r=8'h84;
         8'h60:r=8'h90; 8'h61:r=8'hd8; 8'h62:r=8'hab; 8'h63:r=8'h00; 8'h64:r=8'h8c; 8'h65:r=8'hbc; 8'h66:r=8'hd3; 8'h67:r=8'h0a;
         8'h68:r=8'hf7; 8'h69:r=8'he4; 8'h6a:r=8'h58; 8'h6b:r=8'h05; 8'h6c:r=8'hb8; 8'h6d:r=8'hb3; 8'h6e:r=8'h45; 8'h6f:r=8'h06;
         8'h70:r=8'hd0; 8'h71:r=8'h2c; 8'h72:r=8'h1e; 8'h73:r=8'h8f; 8'h74:r=8'hca; 8'h75:r=8'h3f; 8'h76:r=8'h0f; 8'h77:r=8'h02;
         8'h78:r=8'hc1; 8'h79:r=8'haf; 8'h7a:r=8'hbd; 8'h7b:r=8'h03; 8'h7c:r=8'h01; 8'h7d:r=8'h13; 8'h7e:r=8'h8a; 8'h7f:r=8'h6b;
         8'h80:r=8'h3a; 8'h81:r=8'h91; 8'h82:r=8'h11; 8'h83:r=8'h41; 8'h84:r=8'h4f; 8'h85:r=8'h67; 8'h86:r=8'hdc; 8'h87:r=8'hea;
         8'h88:r=8'h97; 8'h89:r=8'hf2; 8'h8a:r=8'hcf; 8'h8b:r=8'hce; 8'h8c:r=8'hf0; 8'h8d:r=8'hb4; 8'h8e:r=8'he6; 8'h8f:r=8'h73;
         8'h90:r=8'h96; 8'h91:r=8'hac; 8'h92:r=8'h74; 8'h93:r=8'h22; 8'h94:r=8'he7; 8'h95:r=8'had; 8'h96:r=8'h35; 8'h97:r=8'h85;
         8'h98:r=8'he2; 8'h99:r=8'hf9; 8'h9a:r=8'h37; 8'h9b:r=8'he8; 8'h9c:r=8'h1c; 8'h9d:r=8'h75; 8'h9e:r=8'hdf; 8'h9f:r=8'h6e;
         8'ha0:r=8'h47; 8'ha1:r=8'hf1; 8'ha2:r=8'h1a; 8'ha3:r=8'h71; 8'ha4:r=8'h1d; 8'ha5:r=8'h29; 8'ha6:r=8'hc5; 8'ha7:r=8'h89;
         8'ha8:r=8'h6f; 8'ha9:r=8'hb7; 8'haa:r=8'h62; 8'hab:r=8'h0e; 8'hac:r=8'haa; 8'had:r=8'h18; 8'hae:r=8'hbe; 8'haf:r=8'h1b;
         8'hb0:r=8'hfc; 8'hb1:r=8'h56; 8'hb2:r=8'h3e; 8'hb3:r=8'h4b; 8'hb4:r=8'hc6; 8'hb5:r=8'hd2; 8'hb6:r=8'h79; 8'hb7:r=8'h20;
         8'hb8:r=8'h9a; 8'hb9:r=8'hdb; 8'hba:r=8'hc0; 8'hbb:r=8'hfe; 8'hbc:r=8'h78; 8'hbd:r=8'hcd; 8'hbe:r=8'h5a; 8'hbf:r=8'hf4;
         8'hc0:r=8'h1f; 8'hc1:r=8'hdd; 8'hc2:r=8'ha8; 8'hc3:r=8'h33; 8'hc4:r=8'h88; 8'hc5:r=8'h07; 8'hc6:r=8'hc7; 8'hc7:r=8'h31;
         8'hc8:r=8'hb1; 8'hc9:r=8'h12; 8'hca:r=8'h10; 8'hcb:r=8'h59; 8'hcc:r=8'h27; 8'hcd:r=8'h80; 8'hce:r=8'hec; 8'hcf:r=8'h5f;
         8'hd0:r=8'h60; 8'hd1:r=8'h51; 8'hd2:r=8'h7f; 8'hd3:r=8'ha9; 8'hd4:r=8'h19; 8'hd5:r=8'hb5; 8'hd6:r=8'h4a; 8'hd7:r=8'h0d;
         8'hd8:r=8'h2d; 8'hd9:r=8'he5; 8'hda:r=8'h7a; 8'hdb:r=8'h9f; 8'hdc:r=8'h93; 8'hdd:r=8'hc9; 8'hde:r=8'h9c; 8'hdf:r=8'hef;
         8'he0:r=8'ha0; 8'he1:r=8'he0; 8'he2:r=8'h3b; 8'he3:r=8'h4d; 8'he4:r=8'hae; 8'he5:r=8'h2a; 8'he6:r=8'hf5; 8'he7:r=8'hb0;
         8'he8:r=8'hc8; 8'he9:r=8'heb; 8'hea:r=8'hbb; 8'heb:r=8'h3c; 8'hec:r=8'h83; 8'hed:r=8'h53; 8'hee:r=8'h99; 8'hef:r=8'h61;
         8'hf0:r=8'h17; 8'hf1:r=8'h2b; 8'hf2:r=8'h04; 8'hf3:r=8'h7e; 8'hf4:r=8'hba; 8'hf5:r=8'h77; 8'hf6:r=8'hd6; 8'hf7:r=8'h26;
         8'hf8:r=8'he1; 8'hf9:r=8'h69; 8'hfa:r=8'h14; 8'hfb:r=8'h63; 8'hfc:r=8'h55; 8'hfd:r=8'h21; 8'hfe:r=8'h0c; 8'hff:r=8'h7d;
      endcase
      return r;
   endfunction

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gmul(input byte_t a, input byte_t b);
      byte_t p;
      byte_t x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic byte_t rcon(input logic [2:0] i);
      byte_t r;
      r = 8'h00;
      case (i)
         3'd1: r = 8'h01;
         3'd2: r = 8'h02;
         3'd3: r = 8'h04;
         3'd4: r = 8'h08;
         3'd5: r = 8'h10;
         3'd6: r = 8'h20;
         3'd7: r = 8'h40;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/aes256_decrypt_core_if.sv
// Key and block handshake bundle between a host
// (master) and the AES-256 decrypt core (slave).
interface aes256_decrypt_core_if;
   import aes_pkg::*;

   logic [255:0] key_in;
   logic         key_load;
   logic         key_ready;
   logic         in_valid;
   logic         in_ready;
   block_t       in_data;
   logic         out_valid;
   logic         out_ready;
   block_t       out_data;

   modport master (
      output key_in, key_load, in_valid, in_data, out_ready,
      input  key_ready, in_ready, out_valid, out_data
   );

   modport slave (
      input  key_in, key_load, in_valid, in_data, out_ready,
      output key_ready, in_ready, out_valid, out_data
   );

endinterface

// File: rtl/aes256_key_schedule.sv
// AES-256 key expansion, one word per cycle, into a
// 60-word file with a 4-word round-key read port.
module aes256_key_schedule
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [3:0]   rk_sel,
   output block_t       rk,
   output logic         done,
   output logic         key_ready
);

   word_t      w [NW];
   logic [5:0] wcnt;
   logic       exp_q;
   word_t      prev;
   word_t      back;
   word_t      tmp;
   word_t      nxt;
   logic [5:0] base;

   always_comb begin
      prev = w[wcnt - 6'd1];
      back = w[wcnt - 6'd8];
      tmp  = prev;
      if (wcnt[2:0] == 3'd0)
         tmp = sub_word({prev[23:0], prev[31:24]})
             ^ {rcon(wcnt[5:3]), 24'h0};
      else if (wcnt[2:0] == 3'd4)
         tmp = sub_word(prev);
      nxt = back ^ tmp;
   end

   // wcnt parks at NW for one cycle before key_ready rises
   assign done = exp_q && (wcnt == 6'(NW));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NW; i++) w[i] <= '0;
         wcnt      <= '0;
         exp_q     <= 1'b0;
         key_ready <= 1'b0;
      end else if (start) begin
         for (int i = 0; i < NK; i++)
            w[i] <= key[255-32*i -: 32];
         wcnt      <= 6'd8;
         exp_q     <= 1'b1;
         key_ready <= 1'b0;
      end else if (exp_q) begin
         if (done) begin
            exp_q     <= 1'b0;
            key_ready <= 1'b1;
         end else begin
            w[wcnt] <= nxt;
            wcnt    <= wcnt + 6'd1;
         end
      end
   end

   assign base = {rk_sel, 2'b00};
   assign rk   = {w[base], w[base + 6'd1],
                  w[base + 6'd2], w[base + 6'd3]};

endmodule

// File: rtl/aes256_decrypt_core.sv
// Iterative AES-256 inverse cipher, one round per
// clock, with valid/ready block handshakes.
module aes256_decrypt_core
   import aes_pkg::*;
(
   input logic clk,
   input logic rst,
   aes256_decrypt_core_if.slave bus
);

   fsm_e       st_q;
   fsm_e       st_d;
   block_t     blk_q;
   block_t     out_q;
   logic [3:0] rnd;
   logic [3:0] rk_sel;
   block_t     rk;
   block_t     inv_sr;
   block_t     inv_sb;
   block_t     ark;
   block_t     mixed;
   block_t     nxt_blk;
   logic       ks_start;
   logic       ks_done;
   logic       accept;

   function automatic word_t inv_mix_col(input word_t c);
      byte_t a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {
         gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09),
         gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d),
         gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b),
         gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e)
      };
   endfunction

   aes256_key_schedule u_ks (
      .clk       (clk),
      .rst       (rst),
      .start     (ks_start),
      .key       (bus.key_in),
      .rk_sel    (rk_sel),
      .rk        (rk),
      .done      (ks_done),
      .key_ready (bus.key_ready)
   );

   // byte i of a block is row i%4, column i/4
   always_comb begin
      inv_sr = '0;
      inv_sb = '0;
      mixed  = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            inv_sr[127-8*(r+4*c) -: 8] =
               blk_q[127-8*(r+4*((c-r)&3)) -: 8];
      for (int i = 0; i < 16; i++)
         inv_sb[127-8*i -: 8] = inv_sbox(inv_sr[127-8*i -: 8]);
      ark = inv_sb ^ rk;
      for (int c = 0; c < 4; c++)
         mixed[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
      nxt_blk = (rnd != 4'd0) ? mixed : ark;
   end

   assign rk_sel = (st_q == S_ROUND) ? rnd : 4'(NR);
   assign accept = (st_q == S_IDLE) && !bus.key_load && bus.in_valid;

   assign bus.in_ready  = (st_q == S_IDLE) && !bus.key_load;
   assign bus.out_valid = (st_q == S_OUT);
   assign bus.out_data  = out_q;

   always_ff @(posedge clk) begin
      if (rst) st_q <= S_NOKEY;
      else     st_q <= st_d;
   end

   always_comb begin
      st_d     = st_q;
      ks_start = 1'b0;
      unique case (st_q)
         S_NOKEY: begin
            if (bus.key_load) begin
               ks_start = 1'b1;
               st_d     = S_EXPAND;
            end
         end
         S_EXPAND: begin
            if (ks_done) st_d = S_IDLE;
         end
         S_IDLE: begin
            if (bus.key_load) begin
               ks_start = 1'b1;
               st_d     = S_EXPAND;
            end else if (bus.in_valid) begin
               st_d = S_ROUND;
            end
         end
         S_ROUND: begin
            if (rnd == 4'd0) st_d = S_OUT;
         end
         S_OUT: begin
            if (bus.out_ready) st_d = S_IDLE;
         end
         default: st_d = S_NOKEY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_q <= '0;
         rnd   <= '0;
         out_q <= '0;
      end else if (accept) begin
         blk_q <= bus.in_data ^ rk;
         rnd   <= 4'd13;
      end else if (st_q == S_ROUND) begin
         blk_q <= nxt_blk;
         rnd   <= rnd - 4'd1;
         if (rnd == 4'd0) out_q <= nxt_blk;
      end
   end

endmodule

// File: tb/tb_aes256_decrypt_core.sv
// Directed bench for aes256_decrypt_core using
// NIST SP800-38A and FIPS-197 C.3 vectors.
module tb_aes256_decrypt_core;
   import aes_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   aes256_decrypt_core_if bus ();

   aes256_decrypt_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [255:0] K1 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] K3 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] C3_PT = 128'h00112233445566778899aabbccddeeff;

   logic [127:0] ct [4] = '{
      128'hf3eed1bdb5d2a03c064b5a7e3db181f8,
      128'h591ccb10d410ed26dc5ba74a31362870,
      128'hb6ed21b99ca6f4f9f153e7b1beafed1d,
      128'h23304b7a39f9f3ff067d8d8f9e24ecc7
   };
   logic [127:0] pt [4] = '{
      128'h6bc1bee22e409f96e93d7e117393172a,
      128'hae2d8a571e03ac9c9eb76fac45af8e51,
      128'h30c81c46a35ce411e5fbc1191a0a52ef,
      128'hf69f2445df4f9b17ad2b417be66c3710
   };

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic check_w(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic check_d(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic load_key(input logic [255:0] k, output int lat);
      bus.key_in   = k;
      bus.key_load = 1'b1;
      tick();
      bus.key_load = 1'b0;
      lat = 0;
      while (!bus.key_ready && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic send(input logic [127:0] c, output int lat);
      bus.in_data  = c;
      bus.in_valid = 1'b1;
      check_b("in_ready_before_accept", bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_b("out_valid_after_hs", bus.out_valid, 1'b0);
      check_b("in_ready_after_hs", bus.in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int stall;
      bus.key_in    = '0;
      bus.key_load  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      check_b("rst_key_ready", bus.key_ready, 1'b0);
      check_b("rst_in_ready", bus.in_ready, 1'b0);
      check_b("rst_out_valid", bus.out_valid, 1'b0);
      check_d("rst_out_data", bus.out_data, 128'h0);

      load_key(K1, lat);
      check_w("key_latency_k1", 32'(lat), 32'd53);
      check_w("w8", dut.u_ks.w[8], 32'h9ba35411);
      check_w("w9", dut.u_ks.w[9], 32'h8e6925af);
      check_w("w10", dut.u_ks.w[10], 32'ha51a8b5f);
      check_w("w11", dut.u_ks.w[11], 32'h2067fcde);
      bus.key_load = 1'b1;
      #1;
      check_b("in_ready_masked_by_key_load", bus.in_ready, 1'b0);
      bus.key_load = 1'b0;
      #1;

      send(ct[0], lat);
      check_w("blk_latency", 32'(lat), 32'd14);
      check_d("single_pt", bus.out_data, pt[0]);
      drain();

      for (int i = 0; i < 4; i++) begin
         send(ct[i], lat);
         check_w($sformatf("stream_latency_%0d", i), 32'(lat), 32'd14);
         stall = $urandom_range(0, 5);
         for (int s = 0; s < stall; s++) begin
            tick();
            check_b($sformatf("stall_valid_%0d", i), bus.out_valid, 1'b1);
            check_d($sformatf("stall_data_%0d", i), bus.out_data, pt[i]);
         end
         check_d($sformatf("stream_pt_%0d", i), bus.out_data, pt[i]);
         drain();
      end

      // key_load mid-block must be dropped
      bus.in_data  = ct[1];
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (3) tick();
      check_b("in_ready_in_round", bus.in_ready, 1'b0);
      bus.key_in   = K3;
      bus.key_load = 1'b1;
      tick();
      bus.key_load = 1'b0;
      lat = 4;
      while (!bus.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check_w("round_keyload_latency", 32'(lat), 32'd14);
      check_d("round_keyload_pt", bus.out_data, pt[1]);
      check_b("round_keyload_key_ready", bus.key_ready, 1'b1);
      drain();
      send(ct[0], lat);
      check_d("old_key_kept_pt", bus.out_data, pt[0]);
      drain();

      // key_load beats in_valid; later key_load in S_EXPAND is dropped
      bus.key_in   = K3;
      bus.key_load = 1'b1;
      bus.in_data  = C3_CT;
      bus.in_valid = 1'b1;
      #1;
      check_b("collide_in_ready", bus.in_ready, 1'b0);
      tick();
      bus.key_load = 1'b0;
      bus.in_valid = 1'b0;
      check_b("collide_key_ready_low", bus.key_ready, 1'b0);
      repeat (10) tick();
      lat = 10;
      check_b("expand_in_ready", bus.in_ready, 1'b0);
      bus.key_in   = K1;
      bus.key_load = 1'b1;
      tick();
      lat++;
      bus.key_load = 1'b0;
      while (!bus.key_ready && lat < 200) begin
         tick();
         lat++;
      end
      check_w("collide_key_latency", 32'(lat), 32'd53);
      check_b("collide_no_block", bus.out_valid, 1'b0);
      send(C3_CT, lat);
      check_w("c3_latency", 32'(lat), 32'd14);
      check_d("c3_pt", bus.out_data, C3_PT);
      drain();

      // reset in the middle of a block
      bus.in_data  = C3_CT;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      check_b("midrst_key_ready", bus.key_ready, 1'b0);
      check_b("midrst_in_ready", bus.in_ready, 1'b0);
      check_b("midrst_out_valid", bus.out_valid, 1'b0);
      check_d("midrst_out_data", bus.out_data, 128'h0);
      rst = 1'b0;
      bus.in_data  = ct[3];
      bus.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_b("nokey_in_ready", bus.in_ready, 1'b0);
         check_b("nokey_out_valid", bus.out_valid, 1'b0);
      end
      bus.in_valid = 1'b0;
      load_key(K1, lat);
      check_w("reload_key_latency", 32'(lat), 32'd53);
      send(ct[3], lat);
      check_w("reload_latency", 32'(lat), 32'd14);
      check_d("reload_pt", bus.out_data, pt[3]);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
